// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped bidirectional GPIO bank for the picorv32 look-ahead bus.
// Ports: clk/resetn, bus (sel_i, re_i, we_i, addr_i, wstrb_i, wdata_i, rdata_o),
//        pins (gpio_i, gpio_o, gpio_oe), out_wr_o write pulse, irq_o edge interrupt.
module gpio_bank #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VAL   = 32'h0,
    parameter bit          INVERT_OUT  = 1'b1,
    parameter bit          OE_RESET    = 1'b1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sel_i,
    input  logic             re_i,
    input  logic             we_i,
    input  logic [2:0]       addr_i,
    input  logic [3:0]       wstrb_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             out_wr_o,
    output logic             irq_o
);

    localparam logic [2:0] A_DAT = 3'd0;
    localparam logic [2:0] A_SET = 3'd1;
    localparam logic [2:0] A_CLR = 3'd2;
    localparam logic [2:0] A_TGL = 3'd3;
    localparam logic [2:0] A_DIR = 3'd4;
    localparam logic [2:0] A_DIN = 3'd5;
    localparam logic [2:0] A_IEN = 3'd6;
    localparam logic [2:0] A_IST = 3'd7;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_stat;
    logic [WIDTH-1:0] din_prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    logic [31:0]      bmask32;
    logic [31:0]      wbits32;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edg;
    logic [WIDTH-1:0] stat_clr;
    logic [31:0]      rdata_n;
    logic             wr;
    logic             rd;
    logic             unused_hi;

    assign bmask32 = {{8{wstrb_i[3]}}, {8{wstrb_i[2]}},
                      {8{wstrb_i[1]}}, {8{wstrb_i[0]}}};
    assign wbits32 = wdata_i & bmask32;
    assign m       = bmask32[WIDTH-1:0];
    assign wb      = wbits32[WIDTH-1:0];
    // Bits above WIDTH are deliberately dropped.
    assign unused_hi = ^{wbits32, bmask32};

    // A write with no strobes is treated as no access at all.
    assign wr = sel_i && we_i && (wstrb_i != 4'b0000);
    assign rd = sel_i && re_i;

    assign data_in  = sync_q[SYNC_STAGES-1];
    assign edg      = data_in ^ din_prev;
    assign stat_clr = (wr && addr_i == A_IST) ? wb : '0;

    assign gpio_o  = INVERT_OUT ? ~data_out : data_out;
    assign gpio_oe = dir;

    always_comb begin
        rdata_n = '0;
        unique case (addr_i)
            A_DAT:   rdata_n[WIDTH-1:0] = data_out;
            A_DIR:   rdata_n[WIDTH-1:0] = dir;
            A_DIN:   rdata_n[WIDTH-1:0] = data_in;
            A_IEN:   rdata_n[WIDTH-1:0] = irq_en;
            A_IST:   rdata_n[WIDTH-1:0] = irq_stat;
            default: rdata_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out <= RESET_VAL[WIDTH-1:0];
            dir      <= {WIDTH{OE_RESET}};
            irq_en   <= '0;
            irq_stat <= '0;
            sync_q   <= '0;
            din_prev <= '0;
            rdata_o  <= '0;
            out_wr_o <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            out_wr_o <= wr && (addr_i[2] == 1'b0);
            if (wr) begin
                unique case (1'b1)
                    addr_i == A_DAT: data_out <= (data_out & ~m) | wb;
                    addr_i == A_SET: data_out <= data_out | wb;
                    addr_i == A_CLR: data_out <= data_out & ~wb;
                    addr_i == A_TGL: data_out <= data_out ^ wb;
                    addr_i == A_DIR: dir      <= (dir & ~m) | wb;
                    addr_i == A_IEN: irq_en   <= (irq_en & ~m) | wb;
                    default: ;
                endcase
            end
            // New edges override a same-cycle clear.
            irq_stat <= (irq_stat & ~stat_clr) | edg;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            din_prev <= data_in;
            irq_o    <= |(irq_stat & irq_en);
            if (rd) begin
                rdata_o <= rdata_n;
            end
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed table plus randomized model comparison for gpio_bank.
// Drives an 8-bit default bank and a 32-bit bank on a shared bus.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel8 = 1'b0;
    logic        sel32 = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  pin8 = '0;
    logic [31:0] pin32 = '0;

    logic [31:0] rdata8, rdata32;
    logic [7:0]  gpio8, oe8;
    logic [31:0] gpio32, oe32;
    logic        outwr8, outwr32, irq8, irq32;

    int n_chk = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    gpio_bank dut (
        .clk(clk), .resetn(resetn), .sel_i(sel8), .re_i(re), .we_i(we),
        .addr_i(addr), .wstrb_i(wstrb), .wdata_i(wdata), .rdata_o(rdata8),
        .gpio_i(pin8), .gpio_o(gpio8), .gpio_oe(oe8),
        .out_wr_o(outwr8), .irq_o(irq8)
    );

    gpio_bank #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .sel_i(sel32), .re_i(re), .we_i(we),
        .addr_i(addr), .wstrb_i(wstrb), .wdata_i(wdata), .rdata_o(rdata32),
        .gpio_i(pin32), .gpio_o(gpio32), .gpio_oe(oe32),
        .out_wr_o(outwr32), .irq_o(irq32)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model of the 8-bit bank. Pin history: hist[k] is the pin
    // value sampled k+1 edges ago, so DATA_IN is the sample 2 edges back.
    logic [7:0] m_out, m_dir, m_en, m_stat, m_rd;
    bit         m_outwr, m_irq;
    logic [7:0] hist[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_out = 8'h00; m_dir = 8'hFF; m_en = 8'h00; m_stat = 8'h00;
            m_rd = 8'h00; m_outwr = 0; m_irq = 0;
            hist = '{8'h00, 8'h00, 8'h00};
        end else begin
            logic [7:0]  din, chg, v, mk;
            logic [31:0] mask;
            bit          wr;
            din = hist[1];
            chg = hist[1] ^ hist[2];
            mask = 0;
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mask = mask | (32'hFF << (8 * b));
            v  = 8'(wdata & mask);
            mk = 8'(mask);
            wr = sel8 && we && (wstrb != 0);
            m_irq = (m_stat & m_en) != 0;
            m_outwr = wr && addr < 4;
            if (sel8 && re) begin
                case (addr)
                    0: m_rd = m_out;
                    4: m_rd = m_dir;
                    5: m_rd = din;
                    6: m_rd = m_en;
                    7: m_rd = m_stat;
                    default: m_rd = 0;
                endcase
            end
            if (wr && addr == 7) m_stat = m_stat & ~v;
            m_stat = m_stat | chg;
            if (wr) begin
                case (addr)
                    0: m_out = (m_out & ~mk) | v;
                    1: m_out = m_out | v;
                    2: m_out = m_out & ~v;
                    3: m_out = m_out ^ v;
                    4: m_dir = (m_dir & ~mk) | v;
                    6: m_en = (m_en & ~mk) | v;
                    default: ;
                endcase
            end
            hist.push_front(pin8);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("mdl_gpio_o", {24'h0, gpio8}, {24'h0, ~m_out});
            chk("mdl_gpio_oe", {24'h0, oe8}, {24'h0, m_dir});
            chk("mdl_out_wr", {31'h0, outwr8}, {31'h0, m_outwr});
            chk("mdl_irq", {31'h0, irq8}, {31'h0, m_irq});
            chk("mdl_rdata", rdata8, {24'h0, m_rd});
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bus_wr(input bit w32, input logic [2:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        sel8 = !w32; sel32 = w32; we = 1; addr = a; wstrb = s; wdata = d;
        cyc();
        sel8 = 0; sel32 = 0; we = 0; wstrb = 0;
    endtask

    task automatic bus_rd(input bit w32, input logic [2:0] a,
                          output logic [31:0] d);
        sel8 = !w32; sel32 = w32; re = 1; addr = a;
        cyc();
        sel8 = 0; sel32 = 0; re = 0;
        d = w32 ? rdata32 : rdata8;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t tbl[4];
    logic [31:0] rd;
    int pulses;

    initial begin
        tbl[0] = '{3'd0, 32'h5A, 8'hA5};
        tbl[1] = '{3'd1, 32'h81, 8'h24};
        tbl[2] = '{3'd2, 32'h02, 8'h26};
        tbl[3] = '{3'd3, 32'hF0, 8'hD6};

        mon_on = 1;
        cyc(2);
        chk("rst_gpio_o", {24'h0, gpio8}, 32'hFF);
        chk("rst_gpio_oe", {24'h0, oe8}, 32'hFF);
        chk("rst_irq", {31'h0, irq8}, 32'h0);
        chk("rst_rdata", rdata8, 32'h0);
        chk("rst_gpio32", gpio32, 32'hFFFFFFFF);
        resetn = 1;
        bus_rd(0, 7, rd);
        chk("rst_irq_stat", rd, 32'h0);

        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus_wr(0, tbl[i].addr, 4'hF, tbl[i].data);
            chk("tbl_gpio_o", {24'h0, gpio8}, {24'h0, tbl[i].exp_gpio});
            if (outwr8) pulses++;
            cyc();
            chk("tbl_pulse_end", {31'h0, outwr8}, 32'h0);
        end
        chk("tbl_pulses", pulses, 4);
        bus_rd(0, 0, rd);
        chk("rd_data_out", rd, 32'h29);

        bus_wr(1, 0, 4'b0100, 32'hAABBCCDD);
        chk("strb_gpio32", gpio32, 32'hFF44FFFF);
        chk("strb_outwr", {31'h0, outwr32}, 32'h1);
        bus_wr(1, 0, 4'b0000, 32'hFFFFFFFF);
        chk("strb0_outwr", {31'h0, outwr32}, 32'h0);
        chk("strb0_gpio32", gpio32, 32'hFF44FFFF);
        bus_rd(1, 0, rd);
        chk("strb_rd32", rd, 32'h00BB0000);

        bus_wr(0, 6, 4'hF, 32'h01);
        pin8[0] = 1;
        cyc(2);
        bus_rd(0, 5, rd);
        chk("data_in", rd, 32'h01);
        bus_rd(0, 7, rd);
        chk("stat_at3", rd, 32'h01);
        chk("irq_at4", {31'h0, irq8}, 32'h1);

        pin8[3] = 1;
        cyc(4);
        chk("irq_masked", {31'h0, irq8}, 32'h1);
        bus_rd(0, 7, rd);
        chk("stat_both", rd, 32'h09);
        bus_wr(0, 7, 4'hF, 32'h09);
        chk("irq_clr1", {31'h0, irq8}, 32'h1);
        cyc();
        chk("irq_clr2", {31'h0, irq8}, 32'h0);
        bus_rd(0, 7, rd);
        chk("stat_clr", rd, 32'h0);

        pin8[0] = 0;
        cyc(2);
        bus_wr(0, 7, 4'hF, 32'h01);
        cyc();
        chk("coll_irq", {31'h0, irq8}, 32'h1);
        bus_rd(0, 7, rd);
        chk("coll_stat", rd, 32'h01);

        bus_wr(0, 0, 4'hF, 32'h33);
        chk("pre_rst_gpio", {24'h0, gpio8}, 32'hCC);
        #2 resetn = 0;
        #1;
        chk("mid_rst_gpio", {24'h0, gpio8}, 32'hFF);
        chk("mid_rst_oe", {24'h0, oe8}, 32'hFF);
        chk("mid_rst_irq", {31'h0, irq8}, 32'h0);
        chk("mid_rst_rdata", rdata8, 32'h0);
        @(negedge clk);
        cyc();
        resetn = 1;
        bus_rd(0, 7, rd);
        chk("post_rst_stat0", rd, 32'h0);
        cyc(2);
        bus_rd(0, 7, rd);
        chk("post_rst_rise", rd, 32'h08);

        for (int i = 0; i < 600; i++) begin
            int op;
            op = $urandom_range(0, 9);
            sel8 = $urandom_range(0, 9) != 0;
            re = op < 4;
            we = op >= 4 && op < 8;
            addr = 3'($urandom_range(0, 7));
            wstrb = ($urandom_range(0, 3) == 0) ? 4'(   $urandom) : 4'h1;
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) pin8 = pin8 ^ 8'($urandom);
            if (i % 200 == 150) begin
                #2 resetn = 0;
                #2 resetn = 1;
            end
            cyc();
        end
        sel8 = 0; re = 0; we = 0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO bank for the picorv32 system. It replaces the fixed single-byte `out_byte` port with a bank of up to 32 bidirectional pins. The bank adds per-pin direction, atomic set/clear/toggle writes, synchronised inputs and a maskable edge interrupt. It attaches to the core's look-ahead bus (`mem_la_*`) alongside the UART and RAM, with `mem_ready` held high.

## Interface
- `WIDTH`, 8: number of pins, 1–32; register bits above `WIDTH-1` read 0 and ignore writes.
- `RESET_VAL`, 0: reset value of the DATA_OUT register.
- `INVERT_OUT`, 1: when 1, `gpio_o` = ~DATA_OUT (active-low LEDs); when 0, `gpio_o` = DATA_OUT.
- `OE_RESET`, 1: reset value of every DIR bit (1 = output).
- `SYNC_STAGES`, 2: input synchroniser depth, 2–4.
- `clk` in 1: system clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `sel_i` in 1: bank selected (address decode done by the parent).
- `re_i` in 1: look-ahead read (`mem_la_read`).
- `we_i` in 1: look-ahead write (`mem_la_write`).
- `addr_i` in 3: word address (`mem_la_addr[4:2]`).
- `wstrb_i` in 4: byte write strobes.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: registered read data.
- `gpio_i` in WIDTH: asynchronous pin inputs.
- `gpio_o` out WIDTH: pin output values.
- `gpio_oe` out WIDTH: pin output enables (DIR).
- `out_wr_o` out 1: one-cycle pulse on any write to DATA_OUT/SET/CLR/TGL.
- `irq_o` out 1: registered level interrupt.

## Operation
- Register map (word index). Every register is byte-strobe qualified by `wstrb_i`.
  - 0 DATA_OUT, R/W.
  - 1 SET: write-1-sets DATA_OUT bits; reads 0.
  - 2 CLR: write-1-clears DATA_OUT bits; reads 0.
  - 3 TGL: write-1-toggles DATA_OUT bits; reads 0.
  - 4 DIR, R/W.
  - 5 DATA_IN, RO: synchronised pins.
  - 6 IRQ_EN, R/W.
  - 7 IRQ_STAT: reads pending edges; write-1-clears.
- Write accepted when `sel_i && we_i`. Read accepted when `sel_i && re_i`.
- Inputs:
  - `gpio_i` passes through `SYNC_STAGES` flops to form DATA_IN.
  - A further delay flop holds the previous DATA_IN value.
  - An edge is any change of DATA_IN (both polarities).
  - DATA_IN reflects the pins regardless of DIR.
- Edges set IRQ_STAT bits regardless of IRQ_EN.
- `irq_o` <= |(IRQ_STAT & IRQ_EN), registered.
- Simultaneous edge and write-1-clear on the same bit: set wins, bit stays 1.
- `out_wr_o` pulses even when the written value leaves DATA_OUT unchanged.
- Writes with `wstrb_i`=0 have no effect and do not pulse `out_wr_o`.
- Accesses where `sel_i` is low: no state change, `rdata_o` holds its last value.

## Timing
- Reset values (asserted asynchronously, released synchronously by the parent):
  - DATA_OUT=RESET_VAL, so `gpio_o`=RESET_VAL^{WIDTH{INVERT_OUT}}; default 8'hFF.
  - DIR and `gpio_oe`={WIDTH{OE_RESET}}.
  - IRQ_EN=0, IRQ_STAT=0.
  - Synchroniser and delay flops 0.
  - `rdata_o`=0, `out_wr_o`=0, `irq_o`=0.
- Write: register updates at the edge where the write is sampled. `gpio_o`/`gpio_oe` change in the same cycle, with no combinational path from the bus to the pins. `out_wr_o` is high for exactly the following cycle.
- Read: `rdata_o` is loaded at the edge where `re_i` is sampled. It is valid while the core's `mem_valid` is high; zero wait states.
- Pin to DATA_IN: SYNC_STAGES cycles.
- Pin change to IRQ_STAT set: SYNC_STAGES+1 cycles. `irq_o`: one cycle later.
- IRQ_STAT clear to `irq_o` low: 2 cycles, unless a new edge arrives.
- Reset mid-operation:
  - Pending IRQ_STAT is lost.
  - Synchronisers are cleared, so a pin held high appears as a rising edge SYNC_STAGES+1 cycles after release.

## Test plan
- Reset, defaults (WIDTH=8): `gpio_o`=8'hFF, `gpio_oe`=8'hFF, `irq_o`=0; read IRQ_STAT -> 0.
- Write DATA_OUT=0x5A, then SET 0x81, CLR 0x02, TGL 0xF0.
  - `gpio_o` is ~0x5A, ~0xDB, ~0xD9, ~0x29 in turn.
  - `out_wr_o` pulses 4 times, one cycle each.
  - Read DATA_OUT -> 0x29.
- Byte strobes (WIDTH=32): write 0xAABBCCDD to DATA_OUT with wstrb=4'b0100 from reset -> DATA_OUT=0x00BB0000. Write with wstrb=0 -> no change, no `out_wr_o`.
- Edge interrupt:
  - IRQ_EN=0x01, drive `gpio_i[0]` 0->1 -> IRQ_STAT[0] set after 3 cycles, `irq_o` high after 4.
  - `gpio_i[3]` toggle -> IRQ_STAT[3] set, `irq_o` unchanged.
  - Write IRQ_STAT=0x09 -> both clear, `irq_o` low 2 cycles later.
- Clear collision: write-1-clear to IRQ_STAT[0] in the same cycle its edge is detected -> bit remains 1, `irq_o` stays high.
- Reset mid-operation: assert `resetn` low while IRQ_STAT=0x01 and DATA_OUT=0x33 -> all outputs return to reset values immediately, without waiting for a clock edge.
